// File: rtl/uart_receiver.sv
// uart_receiver: oversampled asynchronous serial receiver.
// The line is synchronized, a falling edge starts a frame, and every bit is
// decided by a 2-of-3 majority vote taken around the middle of the bit.
// The stop bit is decided at its middle sample, so the receiver is back in
// IDLE early enough to catch a start bit that follows a single stop bit.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_smp,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxd_data,
    output logic                 rxd_flag,
    output logic                 frame_err,
    output logic                 rx_busy
);

    // Sample-counter positions within one bit period.
    localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SMP_V0   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] SMP_V1   = 4'(OVERSAMPLE / 2);
    localparam logic [3:0] SMP_V2   = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, hist_q;
    logic [3:0]           smp_cnt_q, smp_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic                 vote_q, vote_d;
    logic                 flag_q, flag_d;
    logic                 err_q, err_d;
    logic                 fall;
    logic                 mid_vote;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // A start is a 1->0 transition of the synchronized line; a line held low
    // (break) therefore never re-triggers the receiver.
    assign fall     = hist_q & ~sync2_q;
    // Vote over the two stored mid samples and the current (third) one.
    assign mid_vote = maj3(s0_q, s1_q, sync2_q);

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, sample/vote holding, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            vote_q    <= 1'b0;
            flag_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            smp_cnt_q <= smp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            vote_q    <= vote_d;
            flag_q    <= flag_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: only leaving IDLE ignores clk_smp; everything else
    // advances on sample ticks.
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        vote_d    = vote_q;
        flag_d    = 1'b0;
        err_d     = 1'b0;

        if (state_q == IDLE) begin
            // A tick in the edge cycle is deliberately not counted.
            if (fall) begin
                state_d   = START;
                smp_cnt_d = '0;
            end
        end else if (clk_smp) begin
            smp_cnt_d = smp_cnt_q + 4'd1;

            if (smp_cnt_q == SMP_V0) s0_d = sync2_q;
            if (smp_cnt_q == SMP_V1) s1_d = sync2_q;
            if (smp_cnt_q == SMP_V2) vote_d = mid_vote;

            case (state_q)
                START: begin
                    if (smp_cnt_q == SMP_LAST) begin
                        if (!vote_q) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (smp_cnt_q == SMP_LAST) begin
                        shift_d   = {vote_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) state_d = STOP;
                    end
                end
                STOP: begin
                    if (smp_cnt_q == SMP_V2) begin
                        state_d = IDLE;
                        if (mid_vote) begin
                            data_d = shift_q;
                            flag_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rxd_data  = data_q;
    assign rxd_flag  = flag_q;
    assign frame_err = err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: line-level stimulus for uart_receiver with a scoreboard.
// The line is described as one level per sample tick; the reference model
// decides each bit as the majority of the levels at the bit's middle three
// ticks and predicts the tick on which the receiver reports the frame.
module tb_uart_receiver;
    localparam int DB   = 8;
    localparam int NSMP = 16;
    localparam int FRAME_ELEMS = NSMP * (DB + 2);

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clk_smp = 1'b0;
    logic          rxd     = 1'b1;
    logic [DB-1:0] rxd_data;
    logic          rxd_flag;
    logic          frame_err;
    logic          rx_busy;

    uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(NSMP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_smp   (clk_smp),
        .rxd       (rxd),
        .rxd_data  (rxd_data),
        .rxd_flag  (rxd_flag),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
        int            tick;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    bit            lv[$];
    int            n_checks  = 0;
    int            n_pass    = 0;
    int            tick_n    = 0;
    int            smp_div   = 27;
    int            div_cnt   = 0;
    int            lag       = 0;
    logic [DB-1:0] last_good = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endfunction

    // Sample-tick generator: clk_smp is high for one clk every smp_div clks.
    initial begin
        forever begin
            @(posedge clk);
            if (clk_smp) tick_n++;
            #1;
            if (div_cnt >= smp_div - 1) begin
                clk_smp = 1'b1;
                div_cnt = 0;
            end else begin
                clk_smp = 1'b0;
                div_cnt++;
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (clk_smp !== 1'b1);
        #1;
    endtask

    task automatic drive_elem(input bit v);
        wait_tick();
        rxd = v;
    endtask

    // With a 3-clk tick period the tick falls in the receiver's edge cycle
    // and is skipped, so sampling is one tick later.
    task automatic set_div(input int d);
        smp_div = d;
        lag     = (d == 3) ? 1 : 0;
        drive_elem(1'b1);
        drive_elem(1'b1);
    endtask

    function automatic bit vote_at(input int base);
        int ones = 0;
        for (int k = 7; k <= 9; k++) if (lv[base + k + lag]) ones++;
        return (ones >= 2);
    endfunction

    function automatic void push_expected(input int t0);
        exp_t          e;
        logic [DB-1:0] d;
        for (int j = 0; j < DB; j++) d[j] = vote_at(NSMP * (j + 1));
        e.tick = t0 + 1 + lag + NSMP * (DB + 1) + 9;
        if (vote_at(NSMP * (DB + 1))) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        sb.push_back(e);
    endfunction

    function automatic void build_frame(input logic [DB-1:0] d, input bit stop_v);
        lv.delete();
        for (int k = 0; k < NSMP; k++) lv.push_back(1'b0);
        for (int j = 0; j < DB; j++)
            for (int k = 0; k < NSMP; k++) lv.push_back(d[j]);
        for (int k = 0; k < NSMP; k++) lv.push_back(stop_v);
    endfunction

    task automatic run_lv(input bit expect_out);
        for (int i = 0; i < lv.size(); i++) begin
            drive_elem(lv[i]);
            if (i == 0 && expect_out) push_expected(tick_n);
        end
    endtask

    task automatic send(input logic [DB-1:0] d);
        build_frame(d, 1'b1);
        run_lv(1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_elem(1'b1);
    endtask

    // Monitor: every flag/error pulse pops one expected frame outcome.
    always @(negedge clk) begin
        if (rst_n && (rxd_flag || frame_err)) begin
            check("flag_err_exclusive", 32'(rxd_flag & frame_err), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_output", 32'({rxd_flag, frame_err}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("kind_frame_err", 32'(frame_err), 32'(mon_e.is_err));
                check("rxd_data", 32'(rxd_data), 32'(mon_e.data));
                check("report_tick", 32'(tick_n), 32'(mon_e.tick));
            end
        end
    end

    initial begin
        #1_600_000;
        $display("FAIL watchdog: simulation did not finish, %0d expected outputs pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] d;
        bit            bad;
        int            gap;

        // Reset values.
        repeat (4) @(negedge clk);
        check("rst_rxd_data", 32'(rxd_data), 32'd0);
        check("rst_rxd_flag", 32'(rxd_flag), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;

        // Single 0x55 frame at 27 clk per tick.
        set_div(27);
        send(8'h55);
        idle(3);
        check("busy_after_55", 32'(rx_busy), 32'd0);
        check("drained_55", 32'(sb.size()), 32'd0);

        // Back-to-back frames, single stop bit.
        set_div(8);
        send(8'hA3);
        send(8'h0F);
        idle(3);
        check("drained_b2b", 32'(sb.size()), 32'd0);

        // False start: 4 low ticks, then high.
        lv.delete();
        for (int i = 0; i < 17; i++) lv.push_back(i < 4 ? 1'b0 : 1'b1);
        for (int i = 0; i < 17; i++) begin
            drive_elem(lv[i]);
            if (i == 15) check("busy_false_start", 32'(rx_busy), 32'd1);
            if (i == 16) check("idle_after_false_start", 32'(rx_busy), 32'd0);
        end
        idle(2);

        // Good frame, then a framing error followed by a break.
        send(8'h12);
        build_frame(8'hFF, 1'b0);
        run_lv(1'b1);
        for (int i = 0; i < 30; i++) drive_elem(1'b0);
        check("no_restart_in_break", 32'(rx_busy), 32'd0);
        check("data_kept_after_err", 32'(rxd_data), 32'h12);
        idle(3);
        send(8'h81);
        idle(2);

        // Single-sample glitches rejected by the majority vote.
        build_frame(8'h00, 1'b1);
        lv[NSMP * 3 + 8] = 1'b1;
        run_lv(1'b1);
        build_frame(8'hFF, 1'b1);
        lv[NSMP * 6 + 7] = 1'b0;
        run_lv(1'b1);
        idle(2);

        // Reset in the middle of data bit 4.
        build_frame(8'h99, 1'b1);
        lv = lv[0:NSMP * 5 + 7];
        run_lv(1'b0);
        check("busy_before_reset", 32'(rx_busy), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rxd   = 1'b1;
        #1;
        check("async_rst_rxd_data", 32'(rxd_data), 32'd0);
        check("async_rst_rx_busy", 32'(rx_busy), 32'd0);
        check("async_rst_flag", 32'(rxd_flag), 32'd0);
        check("async_rst_err", 32'(frame_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        last_good = '0;
        set_div(8);
        send(8'h3C);
        idle(2);
        check("drained_after_reset", 32'(sb.size()), 32'd0);

        // Tick coinciding with the start-edge cycle.
        set_div(3);
        send(8'hC5);
        idle(3);

        // Randomized frames: data, stop errors, sample noise, gaps, tick rate.
        for (int f = 0; f < 12; f++) begin
            if (f % 4 == 0) set_div($urandom_range(4, 12));
            d   = DB'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            build_frame(d, !bad);
            for (int i = NSMP; i < NSMP * (DB + 1); i++)
                if ($urandom_range(0, 11) == 0) lv[i] = !lv[i];
            if (!bad)
                for (int i = NSMP * (DB + 1); i < NSMP * (DB + 1) + 10; i++)
                    if ($urandom_range(0, 11) == 0) lv[i] = !lv[i];
            gap = bad ? $urandom_range(1, 3) : $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) lv.push_back(1'b1);
            run_lv(1'b1);
        end
        idle(4);
        check("final_drained", 32'(sb.size()), 32'd0);
        check("final_idle", 32'(rx_busy), 32'd0);
        check("frame_elems_sane", 32'(lv.size() >= FRAME_ELEMS), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
